// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that meters host bursts into uart_top one byte at a time
//
// Purpose:
//   Buffers host bytes pushed at clock rate and hands them to uart_top's
//   wr_en/data_in port one at a time, pacing on uart_top's busy output.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   wr_en     in   host push strobe, one byte per cycle
//   data_in   in   host byte, sampled when wr_en=1
//   full      out  FIFO holds DEPTH bytes
//   empty     out  FIFO holds 0 bytes
//   level     out  occupancy 0..DEPTH
//   overflow  out  sticky, a push was dropped while full
//   ovf_clr   in   clears overflow (a same-cycle drop wins)
//   tx_busy   in   uart_top busy
//   tx_wr_en  out  uart_top wr_en, single-cycle pulse
//   tx_data   out  uart_top data_in, stable from launch until the next pop
//   idle      out  FIFO empty and pacing FSM idle

module uart_tx_fifo #(
    parameter int DEPTH         = 16,
    parameter int START_TIMEOUT = 16,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    data_in,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          ovf_clr,
    input  logic          tx_busy,
    output logic          tx_wr_en,
    output logic [7:0]    tx_data,
    output logic          idle
);

    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic [AW:0]     w_count_nxt;
    logic            r_full;
    logic            r_empty;
    logic            r_overflow;
    logic            r_tx_wr_en;
    logic [7:0]      r_tx_data;
    logic            r_idle;
    logic [TW-1:0]   r_timer;
    logic            w_push;
    logic            w_drop;
    logic            w_pop;

    // Acceptance uses full as registered at the start of the cycle, so a
    // push into a full FIFO is dropped even if a pop frees a slot this edge.
    assign w_push = wr_en & ~r_full;
    assign w_drop = wr_en & r_full;

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_empty && !tx_busy) begin
                    w_pop  = 1'b1;
                    w_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_next = S_WAIT_START;
            end
            S_WAIT_START: begin
                // If busy never rises the byte is assumed sent so the
                // queue cannot stall behind a uart that ignored the strobe.
                if (tx_busy) begin
                    w_next = S_WAIT_DONE;
                end else if (r_timer == TW'(START_TIMEOUT - 1)) begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_tx_wr_en <= 1'b0;
            r_tx_data  <= 8'h00;
            r_idle     <= 1'b1;
            r_timer    <= '0;
        end else begin
            r_state <= w_next;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr    <= r_rptr + AW'(1);
                r_tx_data <= r_mem[r_rptr];
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
            // Registered from next-state so the pulse lines up with LAUNCH.
            r_tx_wr_en <= (w_next == S_LAUNCH);
            r_idle     <= (w_count_nxt == '0) && (w_next == S_IDLE);
            // Timer restarts whenever WAIT_START is (re)entered.
            if (r_state == S_WAIT_START) begin
                r_timer <= r_timer + TW'(1);
            end else begin
                r_timer <= '0;
            end
        end
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign level    = r_count;
    assign overflow = r_overflow;
    assign tx_wr_en = r_tx_wr_en;
    assign tx_data  = r_tx_data;
    assign idle     = r_idle;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo

module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int TMO   = 16;
    localparam int AUTO  = 0;
    localparam int HOLD  = 1;
    localparam int ZERO  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  data_in;
    logic        full;
    logic        empty;
    logic [4:0]  level;
    logic        overflow;
    logic        ovf_clr;
    logic        tx_busy;
    logic        tx_wr_en;
    logic [7:0]  tx_data;
    logic        idle;

    uart_tx_fifo #(.DEPTH(DEPTH), .START_TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .data_in  (data_in),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .tx_busy  (tx_busy),
        .tx_wr_en (tx_wr_en),
        .tx_data  (tx_data),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] q[$];
    logic [7:0] cap[$];
    logic [7:0] last_tx = 8'h00;
    logic       ovf_m = 1'b0;
    logic       prev_wr = 1'b0;
    int         busy_cnt = 0;
    int         mode = AUTO;
    int         cyc_n = 0;
    int         pulse_n = 0;
    int         last_pulse_cyc = -1;
    int         peak = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: observe at the falling edge against the model, advance the
    // uart busy model, then drive the host inputs for the next rising edge.
    task automatic cyc(input logic we, input logic [7:0] d, input logic clr);
        @(negedge clk);
        cyc_n++;
        if (tx_wr_en) begin
            chk("double_pulse", 32'(prev_wr), 32'd0);
            chk("busy_at_launch", 32'(tx_busy), 32'd0);
            if (q.size() == 0) chk("spurious_pulse", 32'd1, 32'd0);
            else last_tx = q.pop_front();
            cap.push_back(tx_data);
            pulse_n++;
            last_pulse_cyc = cyc_n;
        end
        prev_wr = tx_wr_en;
        chk("tx_data", 32'(tx_data), 32'(last_tx));
        chk("level", 32'(level), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        if (q.size() > peak) peak = q.size();
        case (mode)
            HOLD: tx_busy = 1'b1;
            ZERO: tx_busy = 1'b0;
            default: begin
                if (tx_wr_en) begin
                    busy_cnt = $urandom_range(2, 8);
                    tx_busy  = 1'b1;
                end else begin
                    if (busy_cnt > 0) busy_cnt--;
                    if (busy_cnt == 0) tx_busy = 1'b0;
                end
            end
        endcase
        wr_en   = we;
        data_in = d;
        ovf_clr = clr;
        if (rst) begin
            if (clr) ovf_m = 1'b0;
            if (we) begin
                if (q.size() == DEPTH) ovf_m = 1'b1;
                else q.push_back(d);
            end
        end
    endtask

    task automatic drain(input int maxc);
        int k = 0;
        while (!(q.size() == 0 && tx_busy == 1'b0 && idle === 1'b1) && k < maxc) begin
            cyc(1'b0, 8'h00, 1'b0);
            k++;
        end
        chk("drain_done", 32'(k < maxc), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int p0;
        int k;
        int pc;
        rst = 1'b0; wr_en = 1'b0; data_in = 8'h00; ovf_clr = 1'b0; tx_busy = 1'b0;
        repeat (2) cyc(1'b0, 8'h00, 1'b0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_txwr", 32'(tx_wr_en), 32'd0);
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);

        // single byte: latency and loopback
        p0 = pulse_n;
        cyc(1'b1, 8'h12, 1'b0);
        n = cyc_n;
        cyc(1'b0, 8'h00, 1'b0);
        chk("t1_not_idle", 32'(idle), 32'd0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("t1_latency", 32'(last_pulse_cyc), 32'(n + 2));
        drain(60);
        chk("t1_pulses", 32'(pulse_n - p0), 32'd1);
        chk("t1_loop", 32'(cap[cap.size()-1]), 32'h12);
        chk("t1_idle", 32'(idle), 32'd1);

        // burst of three behind a still-busy uart
        cap.delete(); peak = 0;
        tx_busy = 1'b1; busy_cnt = 6;
        cyc(1'b1, 8'h12, 1'b0);
        cyc(1'b1, 8'h50, 1'b0);
        cyc(1'b1, 8'h77, 1'b0);
        drain(120);
        chk("t2_peak", 32'(peak >= 2 && peak <= 3), 32'd1);
        chk("t2_count", 32'(cap.size()), 32'd3);
        chk("t2_b0", 32'(cap[0]), 32'h12);
        chk("t2_b1", 32'(cap[1]), 32'h50);
        chk("t2_b2", 32'(cap[2]), 32'h77);

        // fill past full while busy is held, then clear and drain
        mode = HOLD;
        for (int i = 0; i <= DEPTH; i++) cyc(1'b1, 8'(i), 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_level", 32'(level), 32'd16);
        chk("t3_ovf", 32'(overflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("t3_ovf_clr", 32'(overflow), 32'd0);
        cap.delete();
        mode = AUTO;
        drain(500);
        chk("t3_count", 32'(cap.size()), 32'd16);
        for (int i = 0; i < 16 && i < cap.size(); i++) chk("t3_order", 32'(cap[i]), 32'(i));

        // busy never rises: start timeout
        mode = ZERO;
        p0 = pulse_n;
        cyc(1'b1, 8'hA5, 1'b0);
        k = 0;
        while (pulse_n == p0 && k < 10) begin cyc(1'b0, 8'h00, 1'b0); k++; end
        chk("t4_launch", 32'(pulse_n - p0), 32'd1);
        pc = last_pulse_cyc;
        k = 0;
        while (idle !== 1'b1 && k < 40) begin cyc(1'b0, 8'h00, 1'b0); k++; end
        chk("t4_timeout", 32'(cyc_n - pc), 32'(TMO + 1));
        repeat (5) cyc(1'b0, 8'h00, 1'b0);
        chk("t4_pulses", 32'(pulse_n - p0), 32'd1);

        // asynchronous reset mid-transmission
        mode = AUTO;
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0);
        k = 0;
        while (q.size() != 3 && k < 40) begin cyc(1'b0, 8'h00, 1'b0); k++; end
        chk("t5_level3", 32'(level), 32'd3);
        #3 rst = 1'b0;
        #1;
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_txwr", 32'(tx_wr_en), 32'd0);
        chk("t5_txdata", 32'(tx_data), 32'd0);
        chk("t5_idle", 32'(idle), 32'd1);
        q.delete(); last_tx = 8'h00; ovf_m = 1'b0; prev_wr = 1'b0;
        p0 = pulse_n;
        repeat (2) cyc(1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        repeat (40) cyc(1'b0, 8'h00, 1'b0);
        chk("t5_no_pulse", 32'(pulse_n - p0), 32'd0);

        // full FIFO: push and pop in the same cycle
        mode = HOLD;
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'($urandom), 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("t6_full", 32'(level), 32'd16);
        mode = AUTO;
        cyc(1'b1, 8'hEE, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("t6_level", 32'(level), 32'd15);
        chk("t6_ovf", 32'(overflow), 32'd1);
        drain(500);
        cyc(1'b0, 8'h00, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 99) < 40), 8'($urandom), 1'($urandom_range(0, 19) == 0));
        drain(1500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
